// File: rtl/ise_pkg.sv
// Shared types and constants for the ISE co-processor adapter.
// Opcode codes, field widths and the adapter FSM state set.
package ise_pkg;

   localparam logic [1:0] CUSTOM_0 = 2'd0;
   localparam logic [1:0] CUSTOM_1 = 2'd1;
   localparam logic [1:0] CUSTOM_2 = 2'd2;
   localparam logic [1:0] CUSTOM_3 = 2'd3;

   localparam logic [4:0] OPC_CUSTOM_LO = 5'b01011;

   localparam int ISE_FN_W  = 6;
   localparam int ISE_IMM_W = 7;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      RESP,
      DRAIN,
      REJECT
   } ise_state_t;

endpackage

// File: rtl/ise_insn_decode.sv
// Custom-opcode match and ISE field extraction.
// Purely combinational; the adapter latches the fields on accept.
module ise_insn_decode
   import ise_pkg::*;
#(
   parameter logic [3:0] CUSTOM_MASK = 4'b1110
) (
   input  logic [31:0]          i_insn,
   output logic                 o_match,
   output logic [ISE_FN_W-1:0]  o_fn,
   output logic [ISE_IMM_W-1:0] o_imm
);

   logic [1:0] w_idx;
   logic       w_en;
   logic       w_unused;

   assign w_idx = i_insn[6:5];

   always_comb begin
      w_en = 1'b0;
      unique case (w_idx)
         CUSTOM_0: w_en = CUSTOM_MASK[0];
         CUSTOM_1: w_en = CUSTOM_MASK[1];
         CUSTOM_2: w_en = CUSTOM_MASK[2];
         CUSTOM_3: w_en = CUSTOM_MASK[3];
         default:  w_en = 1'b0;
      endcase
   end

   assign o_match = (i_insn[4:0] == OPC_CUSTOM_LO) && w_en;
   assign o_fn    = {1'b0, i_insn[14:12], w_idx};
   assign o_imm   = i_insn[31:25];

   // Register and rd fields are not needed by the datapath.
   assign w_unused = ^{i_insn[24:15], i_insn[11:7]};

endmodule

// File: rtl/ise_pcpi_adapter.sv
// PCPI issue/response stage in front of the ISE datapath.
// One issue strobe per accepted insn, one ready pulse per claimed insn.
module ise_pcpi_adapter
   import ise_pkg::*;
#(
   parameter int         RESP_STAGES = 1,
   parameter logic [3:0] CUSTOM_MASK = 4'b1110
) (
   input  logic                 ise_clk,
   input  logic                 ise_rst,
   input  logic                 pcpi_valid,
   input  logic [31:0]          pcpi_insn,
   input  logic [31:0]          pcpi_rs1,
   input  logic [31:0]          pcpi_rs2,
   output logic                 pcpi_wait,
   output logic                 pcpi_ready,
   output logic                 pcpi_wr,
   output logic [31:0]          pcpi_rd,
   output logic [ISE_FN_W-1:0]  ise_fn,
   output logic [ISE_IMM_W-1:0] ise_imm,
   output logic [31:0]          ise_in1,
   output logic [31:0]          ise_in2,
   output logic                 ise_val,
   input  logic                 ise_oval,
   input  logic [31:0]          ise_out
);

   localparam logic [1:0] CNT_INIT = 2'(RESP_STAGES);

   ise_state_t            r_state;
   ise_state_t            w_next;
   logic [1:0]            r_cnt;
   logic [31:0]           r_result;
   logic [ISE_FN_W-1:0]   r_fn;
   logic [ISE_IMM_W-1:0]  r_imm;
   logic [31:0]           r_in1;
   logic [31:0]           r_in2;
   logic                  w_match;
   logic [ISE_FN_W-1:0]   w_fn;
   logic [ISE_IMM_W-1:0]  w_imm;
   logic                  w_accept;
   logic                  w_fire;

   ise_insn_decode #(
      .CUSTOM_MASK(CUSTOM_MASK)
   ) u_dec (
      .i_insn (pcpi_insn),
      .o_match(w_match),
      .o_fn   (w_fn),
      .o_imm  (w_imm)
   );

   assign w_accept = (r_state == IDLE) && pcpi_valid && w_match;

   always_ff @(posedge ise_clk or negedge ise_rst) begin
      if (!ise_rst) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // A dropped pcpi_valid always wins: the core has abandoned the insn.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:   if (w_accept) w_next = ISSUE;
         ISSUE:  if (!pcpi_valid)   w_next = IDLE;
                 else if (ise_oval) w_next = RESP;
                 else               w_next = REJECT;
         RESP:   if (!pcpi_valid)        w_next = IDLE;
                 else if (r_cnt == 2'd0) w_next = DRAIN;
         DRAIN:  if (!pcpi_valid) w_next = IDLE;
         REJECT: if (!pcpi_valid) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge ise_clk or negedge ise_rst) begin
      if (!ise_rst) begin
         r_cnt    <= 2'd0;
         r_result <= 32'd0;
         r_fn     <= '0;
         r_imm    <= '0;
         r_in1    <= 32'd0;
         r_in2    <= 32'd0;
      end else begin
         if (w_accept) begin
            r_fn  <= w_fn;
            r_imm <= w_imm;
            r_in1 <= pcpi_rs1;
            r_in2 <= pcpi_rs2;
         end
         if (r_state == ISSUE && ise_oval) begin
            r_result <= ise_out;
            r_cnt    <= CNT_INIT;
         end else if (r_state == RESP && r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
         end
      end
   end

   assign w_fire     = (r_state == RESP) && (r_cnt == 2'd0);
   assign pcpi_ready = w_fire;
   assign pcpi_wr    = w_fire;
   assign pcpi_rd    = w_fire ? r_result : 32'd0;
   assign pcpi_wait  = (r_state == ISSUE) || (r_state == RESP);
   assign ise_val    = (r_state == ISSUE);
   assign ise_fn     = r_fn;
   assign ise_imm    = r_imm;
   assign ise_in1    = r_in1;
   assign ise_in2    = r_in2;

endmodule

// File: tb/tb_ise_pcpi_adapter.sv
// Bench for ise_pcpi_adapter with a behavioural ISE datapath stand-in.
// Vector table, corner sequences, random insns; RESP_STAGES 0..3 swept alongside.
module tb_ise_pcpi_adapter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic [31:0] insn, rs1, rs2;
   logic        wait_o, ready, wr, val, oval;
   logic [31:0] rd, in1, in2, dout;
   logic [5:0]  fn;
   logic [6:0]  imm;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Datapath stand-in: claims every funct7 except 0x3F.
   function automatic logic dp_claim(input logic [6:0] f7);
      return f7 != 7'h3F;
   endfunction

   function automatic logic [31:0] dp_res(input logic [31:0] x, input logic [31:0] y,
                                          input logic [6:0] f7, input logic [5:0] f);
      return (x + y + {25'd0, f7}) ^ {26'd0, f};
   endfunction

   assign oval = val && dp_claim(imm);
   assign dout = dp_res(in1, in2, imm, fn);

   ise_pcpi_adapter dut (
      .ise_clk(clk), .ise_rst(rst_n), .pcpi_valid(valid),
      .pcpi_insn(insn), .pcpi_rs1(rs1), .pcpi_rs2(rs2),
      .pcpi_wait(wait_o), .pcpi_ready(ready), .pcpi_wr(wr), .pcpi_rd(rd),
      .ise_fn(fn), .ise_imm(imm), .ise_in1(in1), .ise_in2(in2),
      .ise_val(val), .ise_oval(oval), .ise_out(dout)
   );

   logic [3:0]  sw_ready, sw_wait, sw_bad;
   logic [31:0] sw_rd [4];

   for (genvar k = 0; k < 4; k++) begin : g_sw
      logic        w_wait, w_ready, w_wr, w_val, w_oval;
      logic [31:0] w_rd, w_in1, w_in2, w_out;
      logic [5:0]  w_fn;
      logic [6:0]  w_imm;
      assign w_oval = w_val && dp_claim(w_imm);
      assign w_out  = dp_res(w_in1, w_in2, w_imm, w_fn);
      ise_pcpi_adapter #(.RESP_STAGES(k)) u_sw (
         .ise_clk(clk), .ise_rst(rst_n), .pcpi_valid(valid),
         .pcpi_insn(insn), .pcpi_rs1(rs1), .pcpi_rs2(rs2),
         .pcpi_wait(w_wait), .pcpi_ready(w_ready), .pcpi_wr(w_wr), .pcpi_rd(w_rd),
         .ise_fn(w_fn), .ise_imm(w_imm), .ise_in1(w_in1), .ise_in2(w_in2),
         .ise_val(w_val), .ise_oval(w_oval), .ise_out(w_out)
      );
      assign sw_ready[k] = w_ready;
      assign sw_wait[k]  = w_wait;
      assign sw_rd[k]    = w_rd;
      assign sw_bad[k]   = (w_wr != w_ready) || (!w_ready && (w_rd != 32'd0));
   end

   // Reference model, straight from the instruction encoding.
   function automatic logic [5:0] m_fn(input logic [31:0] i);
      return {1'b0, i[14:12], i[6:5]};
   endfunction

   function automatic bit m_issue(input logic [31:0] i);
      logic [3:0] mask;
      mask = 4'b1110;
      return (i[4:0] == 5'b01011) && mask[i[6:5]];
   endfunction

   function automatic bit m_resp(input logic [31:0] i);
      return m_issue(i) && (i[31:25] != 7'h3F);
   endfunction

   function automatic logic [31:0] m_rd(input logic [31:0] i, input logic [31:0] a,
                                        input logic [31:0] b);
      return dp_res(a, b, i[31:25], m_fn(i));
   endfunction

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [1:0] idx);
      return {f7, 5'd2, 5'd1, f3, 5'd3, idx, 5'b01011};
   endfunction

   task automatic chk(input string nm, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int          t_nval, t_nrdy, t_lat, t_nwait, t_bad;
   logic [31:0] t_rd;
   int          t_swlat [4];
   int          t_swwait [4];
   logic [31:0] t_swrd [4];

   task automatic obs(input int c);
      if (val) t_nval++;
      if (wait_o) t_nwait++;
      if (ready) begin
         t_nrdy++;
         if (t_lat < 0) t_lat = c;
         t_rd = rd;
      end
      if ((wr != ready) || (!ready && rd != 32'd0)) t_bad++;
      for (int k = 0; k < 4; k++) begin
         if (sw_ready[k] && t_swlat[k] < 0) begin
            t_swlat[k] = c;
            t_swrd[k]  = sw_rd[k];
         end
         if (sw_wait[k]) t_swwait[k]++;
         if (sw_bad[k]) t_bad++;
      end
   endtask

   // Present one insn, hold valid `hold` cycles past ready (or 24 cycles if unanswered).
   task automatic run_txn(input logic [31:0] i, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
      int  since;
      bit  done;
      t_nval = 0; t_nrdy = 0; t_lat = -1; t_nwait = 0; t_bad = 0; t_rd = 32'd0;
      for (int k = 0; k < 4; k++) begin
         t_swlat[k] = -1; t_swwait[k] = 0; t_swrd[k] = 32'd0;
      end
      insn = i; rs1 = a; rs2 = b; valid = 1'b1;
      since = -1;
      for (int c = 1; c <= 24; c++) begin
         tick();
         obs(c);
         if (t_lat >= 0) since++;
         done = 1'b1;
         for (int k = 0; k < 4; k++) if (t_swlat[k] < 0) done = 1'b0;
         if (since >= hold && done) break;
      end
      valid = 1'b0;
      for (int c = 25; c <= 28; c++) begin
         tick();
         obs(c);
      end
   endtask

   task automatic check_txn(input string nm, input logic [31:0] i,
                            input logic [31:0] a, input logic [31:0] b, input int hold);
      bit ev, er;
      ev = m_issue(i);
      er = m_resp(i);
      run_txn(i, a, b, hold);
      chk({nm, "_val"}, t_nval, ev ? 1 : 0);
      chk({nm, "_rdy"}, t_nrdy, er ? 1 : 0);
      chk({nm, "_wait"}, t_nwait, er ? 3 : (ev ? 1 : 0));
      chk({nm, "_wr"}, t_bad, 0);
      chk({nm, "_lat"}, t_lat, er ? 3 : -1);
      if (er) begin
         chk32({nm, "_rd"}, t_rd, m_rd(i, a, b));
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_swlat%0d", nm, k), t_swlat[k], 2 + k);
            chk($sformatf("%s_swwait%0d", nm, k), t_swwait[k], 2 + k);
            chk32($sformatf("%s_swrd%0d", nm, k), t_swrd[k], m_rd(i, a, b));
         end
      end
      if (ev) begin
         chk32({nm, "_in1"}, in1, a);
         chk32({nm, "_in2"}, in2, b);
         chk32({nm, "_fn"}, {26'd0, fn}, {26'd0, m_fn(i)});
         chk32({nm, "_imm"}, {25'd0, imm}, {25'd0, i[31:25]});
      end
   endtask

   typedef struct {
      logic [31:0] insn;
      logic [31:0] a;
      logic [31:0] b;
      int          hold;
   } vec_t;

   vec_t        vt [7];
   logic [31:0] ri, ra, rb;
   int          cnt;

   initial begin
      vt[0] = '{mk(7'h00, 3'b000, 2'b01), 32'h1,        32'h2,        0};
      vt[1] = '{mk(7'h00, 3'b000, 2'b00), 32'h5,        32'h6,        0};
      vt[2] = '{mk(7'h3F, 3'b010, 2'b11), 32'h11,       32'h22,       0};
      vt[3] = '{mk(7'h05, 3'b101, 2'b10), 32'hCAFE0000, 32'h0000BABE, 1};
      vt[4] = '{mk(7'h12, 3'b111, 2'b11), 32'h12345678, 32'h9ABCDEF0, 3};
      vt[5] = '{32'h00B50533,             32'h7,        32'h8,        0};
      vt[6] = '{mk(7'h7F, 3'b001, 2'b01), 32'hFFFFFFFF, 32'h1,        2};

      rst_n = 1'b0; valid = 1'b0; insn = 32'd0; rs1 = 32'd0; rs2 = 32'd0;
      repeat (3) tick();
      chk32("rst_ctl", {28'd0, wait_o, ready, wr, val}, 32'd0);
      chk32("rst_rd", rd, 32'd0);
      chk32("rst_in", in1 | in2, 32'd0);
      chk32("rst_fld", {19'd0, fn, imm}, 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      for (int v = 0; v < 7; v++)
         check_txn($sformatf("vec%0d", v), vt[v].insn, vt[v].a, vt[v].b, vt[v].hold);

      // Abort in RESP: no ready for the dropped insn, next insn accepted at once.
      insn = mk(7'h00, 3'b000, 2'b01); rs1 = 32'h5; rs2 = 32'h6; valid = 1'b1;
      tick();
      chk("abort_val", int'(val), 1);
      tick();
      chk("abort_wait", int'(wait_o), 1);
      valid = 1'b0;
      tick();
      chk("abort_rdy", int'(ready | wait_o | val), 0);
      check_txn("after_abort", mk(7'h03, 3'b011, 2'b10), 32'hA0, 32'h0B, 0);

      // Abort coinciding with ISSUE.
      insn = mk(7'h01, 3'b000, 2'b01); rs1 = 32'h9; rs2 = 32'h9; valid = 1'b1;
      tick();
      chk("abort_iss_val", int'(val), 1);
      valid = 1'b0;
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (ready) cnt++;
      end
      chk("abort_iss_rdy", cnt, 0);

      // Reset while in RESP.
      insn = mk(7'h00, 3'b000, 2'b01); rs1 = 32'h3; rs2 = 32'h4; valid = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk32("midrst_ctl", {28'd0, wait_o, ready, wr, val}, 32'd0);
      chk32("midrst_dat", rd | in1 | in2 | {19'd0, fn, imm}, 32'd0);
      valid = 1'b0;
      tick();
      rst_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (ready) cnt++;
      end
      chk("midrst_rdy", cnt, 0);
      check_txn("after_rst", mk(7'h00, 3'b000, 2'b01), 32'h1, 32'h2, 0);

      for (int r = 0; r < 40; r++) begin
         ri = $urandom;
         if ($urandom_range(3) != 0) ri[4:0] = 5'b01011;
         if ($urandom_range(3) == 0) ri[31:25] = 7'h3F;
         ra = $urandom;
         rb = $urandom;
         check_txn($sformatf("rnd%0d", r), ri, ra, rb, int'($urandom_range(3)));
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
